reg_access_ctrl: RTL and testbench

Register-file initiator: sits between decode/execute and the 16-bit `RegisterFile`, and owns both of its ports.

- **Read side:** accepts operand-fetch requests, drives the register file read addresses and returns captured operands over a valid/ready handshake.
- **Write side:** arbitrates two write-back sources (ALU, memory) into the single write port.
- **Hazards:** a per-register scoreboard stalls reads of registers with writes in flight; a one-cycle bypass covers the write-landing edge.

---
 rtl/cpu_pkg.sv | 26 ++
 rtl/reg_access_ctrl_if.sv | 63 ++++++
 rtl/reg_scoreboard.sv | 44 ++++
 rtl/reg_access_ctrl.sv | 151 +++++++++++++++
 tb/tb_reg_access_ctrl.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared constants, state and write-back source encodings for the register-file
// access path.
package cpu_pkg;

  localparam int DATA_W   = 16;
  localparam int ADDR_W   = 4;
  localparam int NUM_REGS = 13;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_HAZ,
    HOLD
  } rac_state_t;

  typedef enum logic [1:0] {
    WB_NONE,
    WB_ALU,
    WB_MEM
  } wb_src_t;

  // Addresses at or above NUM_REGS name registers that do not exist.
  function automatic logic addr_legal(input logic [ADDR_W-1:0] addr);
    return {1'b0, addr} < (ADDR_W + 1)'(NUM_REGS);
  endfunction

endpackage

// File: rtl/reg_access_ctrl_if.sv
// Bundle of fetch, operand, write-back and register-file port signals owned by
// reg_access_ctrl; slave is the controller, master is its environment.
interface reg_access_ctrl_if;
  import cpu_pkg::*;

  logic              rd_req_valid;
  logic              rd_req_ready;
  logic [ADDR_W-1:0] rd_req_src1;
  logic [ADDR_W-1:0] rd_req_src2;
  logic [ADDR_W-1:0] rd_req_dst;
  logic              rd_req_dst_en;

  logic              op_valid;
  logic              op_ready;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic [ADDR_W-1:0] op_dst;

  logic              wb_alu_valid;
  logic [ADDR_W-1:0] wb_alu_addr;
  logic [DATA_W-1:0] wb_alu_data;
  logic              wb_mem_valid;
  logic              wb_mem_ready;
  logic [ADDR_W-1:0] wb_mem_addr;
  logic [DATA_W-1:0] wb_mem_data;

  logic [ADDR_W-1:0] rf_read_addr1;
  logic [ADDR_W-1:0] rf_read_addr2;
  logic [DATA_W-1:0] rf_read_data1;
  logic [DATA_W-1:0] rf_read_data2;
  logic              rf_write_enable;
  logic [ADDR_W-1:0] rf_write_addr;
  logic [DATA_W-1:0] rf_write_data;

  logic              err_addr;

  modport slave (
    input  rd_req_valid, rd_req_src1, rd_req_src2, rd_req_dst, rd_req_dst_en,
    output rd_req_ready,
    output op_valid, op_a, op_b, op_dst,
    input  op_ready,
    input  wb_alu_valid, wb_alu_addr, wb_alu_data,
    input  wb_mem_valid, wb_mem_addr, wb_mem_data,
    output wb_mem_ready,
    output rf_read_addr1, rf_read_addr2, rf_write_enable, rf_write_addr, rf_write_data,
    input  rf_read_data1, rf_read_data2,
    output err_addr
  );

  modport master (
    output rd_req_valid, rd_req_src1, rd_req_src2, rd_req_dst, rd_req_dst_en,
    input  rd_req_ready,
    input  op_valid, op_a, op_b, op_dst,
    output op_ready,
    output wb_alu_valid, wb_alu_addr, wb_alu_data,
    output wb_mem_valid, wb_mem_addr, wb_mem_data,
    input  wb_mem_ready,
    input  rf_read_addr1, rf_read_addr2, rf_write_enable, rf_write_addr, rf_write_data,
    output rf_read_data1, rf_read_data2,
    input  err_addr
  );

endinterface

// File: rtl/reg_scoreboard.sv
// One pending bit per implemented register: set marks a write in flight, clear
// retires it; a same-edge set beats the clear because it names a newer producer.
module reg_scoreboard
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              set_en,
  input  logic [ADDR_W-1:0] set_addr,
  input  logic              clr_en,
  input  logic [ADDR_W-1:0] clr_addr,
  input  logic [ADDR_W-1:0] lk1_addr,
  output logic              lk1_pending,
  input  logic [ADDR_W-1:0] lk2_addr,
  output logic              lk2_pending
);

  logic [NUM_REGS-1:0] pending;

  always_ff @(posedge clk) begin
    if (reset) begin
      pending <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (set_en && (set_addr == ADDR_W'(i))) begin
          pending[i] <= 1'b1;
        end else if (clr_en && (clr_addr == ADDR_W'(i))) begin
          pending[i] <= 1'b0;
        end
      end
    end
  end

  // Out-of-range addresses never match an entry and so read as not pending.
  always_comb begin
    lk1_pending = 1'b0;
    lk2_pending = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (lk1_addr == ADDR_W'(i)) lk1_pending = pending[i];
      if (lk2_addr == ADDR_W'(i)) lk2_pending = pending[i];
    end
  end

endmodule

// File: rtl/reg_access_ctrl.sv
// Register-file initiator: operand fetch with scoreboard stalls and write-landing
// bypass, plus ALU-over-memory arbitration into a registered write port.
module reg_access_ctrl
  import cpu_pkg::*;
(
  input logic              clk,
  input logic              reset,
  reg_access_ctrl_if.slave bus
);

  rac_state_t        state, state_next;
  logic [ADDR_W-1:0] src1_q, src2_q, dst_q;
  logic              dst_en_q;
  logic [DATA_W-1:0] op_a_q, op_b_q;
  logic              wb_valid_q;
  logic [ADDR_W-1:0] wb_addr_q;
  logic [DATA_W-1:0] wb_data_q;
  logic              err_q;

  logic              req_fire, req_illegal;
  logic              pend1, pend2, hit1, hit2, ok1, ok2, both_ok, sb_set;
  logic [DATA_W-1:0] opnd1, opnd2;
  wb_src_t           wb_src;
  logic [ADDR_W-1:0] wb_addr_sel;
  logic [DATA_W-1:0] wb_data_sel;
  logic              wb_legal;

  assign req_fire    = (state == IDLE) && bus.rd_req_valid;
  assign req_illegal = !addr_legal(bus.rd_req_src1) || !addr_legal(bus.rd_req_src2) ||
                       (bus.rd_req_dst_en && !addr_legal(bus.rd_req_dst));

  reg_scoreboard u_scoreboard (
    .clk         (clk),
    .reset       (reset),
    .set_en      (sb_set),
    .set_addr    (dst_q),
    .clr_en      (wb_valid_q),
    .clr_addr    (wb_addr_q),
    .lk1_addr    (src1_q),
    .lk1_pending (pend1),
    .lk2_addr    (src2_q),
    .lk2_pending (pend2)
  );

  // A write landing this edge resolves its source and supplies the operand,
  // since the register file only shows the new value a cycle later.
  always_comb begin
    hit1    = wb_valid_q && (wb_addr_q == src1_q);
    hit2    = wb_valid_q && (wb_addr_q == src2_q);
    ok1     = !addr_legal(src1_q) || !pend1 || hit1;
    ok2     = !addr_legal(src2_q) || !pend2 || hit2;
    both_ok = ok1 && ok2;
    opnd1   = !addr_legal(src1_q) ? '0 : (hit1 ? wb_data_q : bus.rf_read_data1);
    opnd2   = !addr_legal(src2_q) ? '0 : (hit2 ? wb_data_q : bus.rf_read_data2);
    sb_set  = (state == WAIT_HAZ) && both_ok && dst_en_q && addr_legal(dst_q);
  end

  always_comb begin
    wb_src      = WB_NONE;
    wb_addr_sel = '0;
    wb_data_sel = '0;
    if (bus.wb_alu_valid) begin
      wb_src      = WB_ALU;
      wb_addr_sel = bus.wb_alu_addr;
      wb_data_sel = bus.wb_alu_data;
    end else if (bus.wb_mem_valid) begin
      wb_src      = WB_MEM;
      wb_addr_sel = bus.wb_mem_addr;
      wb_data_sel = bus.wb_mem_data;
    end
    wb_legal = addr_legal(wb_addr_sel);
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (bus.rd_req_valid) state_next = WAIT_HAZ;
      WAIT_HAZ: if (both_ok)          state_next = HOLD;
      HOLD:     if (bus.op_ready)     state_next = IDLE;
      default:                        state_next = IDLE;
    endcase
  end

  // Every output is forced low while reset is asserted, even before the reset edge.
  always_comb begin
    bus.rd_req_ready    = 1'b0;
    bus.op_valid        = 1'b0;
    bus.op_a            = '0;
    bus.op_b            = '0;
    bus.op_dst          = '0;
    bus.wb_mem_ready    = 1'b0;
    bus.rf_read_addr1   = '0;
    bus.rf_read_addr2   = '0;
    bus.rf_write_enable = 1'b0;
    bus.rf_write_addr   = '0;
    bus.rf_write_data   = '0;
    bus.err_addr        = 1'b0;
    if (!reset) begin
      bus.rd_req_ready    = (state == IDLE);
      bus.op_valid        = (state == HOLD);
      bus.op_a            = op_a_q;
      bus.op_b            = op_b_q;
      bus.op_dst          = dst_q;
      bus.wb_mem_ready    = !bus.wb_alu_valid;
      bus.rf_read_addr1   = src1_q;
      bus.rf_read_addr2   = src2_q;
      bus.rf_write_enable = wb_valid_q;
      bus.rf_write_addr   = wb_addr_q;
      bus.rf_write_data   = wb_data_q;
      bus.err_addr        = err_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      src1_q     <= '0;
      src2_q     <= '0;
      dst_q      <= '0;
      dst_en_q   <= 1'b0;
      op_a_q     <= '0;
      op_b_q     <= '0;
      wb_valid_q <= 1'b0;
      wb_addr_q  <= '0;
      wb_data_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      if (req_fire) begin
        src1_q   <= bus.rd_req_src1;
        src2_q   <= bus.rd_req_src2;
        dst_q    <= bus.rd_req_dst;
        dst_en_q <= bus.rd_req_dst_en;
      end
      if ((state == WAIT_HAZ) && both_ok) begin
        op_a_q <= opnd1;
        op_b_q <= opnd2;
      end
      wb_valid_q <= (wb_src != WB_NONE) && wb_legal;
      wb_addr_q  <= wb_addr_sel;
      wb_data_q  <= wb_data_sel;
      if ((req_fire && req_illegal) || ((wb_src != WB_NONE) && !wb_legal)) begin
        err_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_reg_access_ctrl.sv
// Directed bench for reg_access_ctrl: a behavioural register file on the rf
// ports, with each observation compared against hand-computed values.
module tb_reg_access_ctrl;
  import cpu_pkg::*;

  logic clk;
  logic reset;
  int   errors;
  int   checks;
  int   lat;

  reg_access_ctrl_if bus ();

  reg_access_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file model: combinational reads, writes on the rising edge.
  logic [DATA_W-1:0] rf_mem [16];

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) rf_mem[i] <= '0;
    end else if (bus.rf_write_enable) begin
      rf_mem[bus.rf_write_addr] <= bus.rf_write_data;
    end
  end

  assign bus.rf_read_data1 = rf_mem[bus.rf_read_addr1];
  assign bus.rf_read_data2 = rf_mem[bus.rf_read_addr2];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Presents a fetch request and returns in the cycle after it was accepted.
  task automatic applyStimulus(input logic [ADDR_W-1:0] s1, input logic [ADDR_W-1:0] s2,
                               input logic [ADDR_W-1:0] d, input logic d_en);
    int n;
    bus.rd_req_valid  = 1'b1;
    bus.rd_req_src1   = s1;
    bus.rd_req_src2   = s2;
    bus.rd_req_dst    = d;
    bus.rd_req_dst_en = d_en;
    #1;
    n = 0;
    while (!bus.rd_req_ready && n < 20) begin
      step();
      n++;
    end
    checkOutput("req_accept", 32'(bus.rd_req_ready), 32'd1);
    step();
    bus.rd_req_valid = 1'b0;
  endtask

  task automatic wait_op(input int max_cycles, output int cycles);
    cycles = 0;
    while (!bus.op_valid && cycles < max_cycles) begin
      step();
      cycles++;
    end
  endtask

  task automatic consume();
    bus.op_ready = 1'b1;
    step();
    bus.op_ready = 1'b0;
  endtask

  task automatic alu_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    bus.wb_alu_valid = 1'b1;
    bus.wb_alu_addr  = a;
    bus.wb_alu_data  = d;
    step();
    bus.wb_alu_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    errors = 0;
    checks = 0;
    reset  = 1'b1;
    bus.rd_req_valid  = 1'b0;
    bus.rd_req_src1   = '0;
    bus.rd_req_src2   = '0;
    bus.rd_req_dst    = '0;
    bus.rd_req_dst_en = 1'b0;
    bus.op_ready      = 1'b0;
    bus.wb_alu_valid  = 1'b0;
    bus.wb_alu_addr   = '0;
    bus.wb_alu_data   = '0;
    bus.wb_mem_valid  = 1'b0;
    bus.wb_mem_addr   = '0;
    bus.wb_mem_data   = '0;
    step();
    step();

    checkOutput("rst_rd_req_ready", 32'(bus.rd_req_ready), 32'd0);
    checkOutput("rst_op_valid", 32'(bus.op_valid), 32'd0);
    checkOutput("rst_rf_we", 32'(bus.rf_write_enable), 32'd0);
    checkOutput("rst_err_addr", 32'(bus.err_addr), 32'd0);
    checkOutput("rst_wb_mem_ready", 32'(bus.wb_mem_ready), 32'd0);
    reset = 1'b0;
    #1;
    checkOutput("post_rst_ready", 32'(bus.rd_req_ready), 32'd1);

    // Preload R3 and R5 through the ALU write-back path.
    alu_write(4'd3, 16'h1234);
    checkOutput("wb_we", 32'(bus.rf_write_enable), 32'd1);
    checkOutput("wb_addr", 32'(bus.rf_write_addr), 32'd3);
    checkOutput("wb_data", 32'(bus.rf_write_data), 32'h1234);
    alu_write(4'd5, 16'hBEEF);
    step();

    // Plain fetch, no hazard.
    applyStimulus(4'd3, 4'd5, 4'd0, 1'b0);
    checkOutput("rd_addr1", 32'(bus.rf_read_addr1), 32'd3);
    checkOutput("rd_addr2", 32'(bus.rf_read_addr2), 32'd5);
    wait_op(8, lat);
    checkOutput("fetch_latency", 32'(lat), 32'd1);
    checkOutput("plain_op_a", 32'(bus.op_a), 32'h1234);
    checkOutput("plain_op_b", 32'(bus.op_b), 32'hBEEF);
    step();
    checkOutput("hold_valid", 32'(bus.op_valid), 32'd1);
    checkOutput("hold_op_a", 32'(bus.op_a), 32'h1234);
    consume();
    checkOutput("idle_op_valid", 32'(bus.op_valid), 32'd0);
    checkOutput("idle_ready", 32'(bus.rd_req_ready), 32'd1);

    // RAW stall on R7, released by an ALU write caught through the bypass.
    applyStimulus(4'd0, 4'd0, 4'd7, 1'b1);
    wait_op(8, lat);
    checkOutput("issue_op_dst", 32'(bus.op_dst), 32'd7);
    consume();
    applyStimulus(4'd7, 4'd3, 4'd0, 1'b0);
    step();
    step();
    step();
    checkOutput("raw_stall", 32'(bus.op_valid), 32'd0);
    alu_write(4'd7, 16'h00AA);
    checkOutput("raw_landing_cycle", 32'(bus.op_valid), 32'd0);
    step();
    checkOutput("raw_release", 32'(bus.op_valid), 32'd1);
    checkOutput("raw_bypass_op_a", 32'(bus.op_a), 32'h00AA);
    checkOutput("raw_op_b", 32'(bus.op_b), 32'h1234);
    consume();
    applyStimulus(4'd7, 4'd0, 4'd0, 1'b0);
    wait_op(8, lat);
    checkOutput("pend7_cleared", 32'(lat), 32'd1);
    checkOutput("r7_from_rf", 32'(bus.op_a), 32'h00AA);
    consume();

    // ALU and memory both target R2 in the same cycle.
    bus.wb_alu_valid = 1'b1;
    bus.wb_alu_addr  = 4'd2;
    bus.wb_alu_data  = 16'h1111;
    bus.wb_mem_valid = 1'b1;
    bus.wb_mem_addr  = 4'd2;
    bus.wb_mem_data  = 16'h2222;
    #1;
    checkOutput("arb_mem_stalled", 32'(bus.wb_mem_ready), 32'd0);
    step();
    bus.wb_alu_valid = 1'b0;
    #1;
    checkOutput("arb_mem_ready", 32'(bus.wb_mem_ready), 32'd1);
    checkOutput("arb_alu_first", 32'(bus.rf_write_data), 32'h1111);
    step();
    bus.wb_mem_valid = 1'b0;
    checkOutput("arb_mem_addr", 32'(bus.rf_write_addr), 32'd2);
    checkOutput("arb_mem_second", 32'(bus.rf_write_data), 32'h2222);
    step();
    applyStimulus(4'd2, 4'd0, 4'd0, 1'b0);
    wait_op(8, lat);
    checkOutput("r2_final", 32'(bus.op_a), 32'h2222);
    consume();

    // Illegal write and source addresses.
    checkOutput("err_before_illegal", 32'(bus.err_addr), 32'd0);
    alu_write(4'd14, 16'h5555);
    checkOutput("illegal_wr_suppressed", 32'(bus.rf_write_enable), 32'd0);
    checkOutput("illegal_wr_err", 32'(bus.err_addr), 32'd1);
    applyStimulus(4'd15, 4'd3, 4'd0, 1'b0);
    wait_op(8, lat);
    checkOutput("illegal_src_latency", 32'(lat), 32'd1);
    checkOutput("illegal_src_op_a", 32'(bus.op_a), 32'h0000);
    checkOutput("illegal_src_op_b", 32'(bus.op_b), 32'h1234);
    consume();

    // R4 write lands on the same edge that marks R4 pending again.
    bus.rd_req_valid  = 1'b1;
    bus.rd_req_src1   = 4'd0;
    bus.rd_req_src2   = 4'd0;
    bus.rd_req_dst    = 4'd4;
    bus.rd_req_dst_en = 1'b1;
    bus.wb_alu_valid  = 1'b1;
    bus.wb_alu_addr   = 4'd4;
    bus.wb_alu_data   = 16'h4444;
    step();
    bus.rd_req_valid = 1'b0;
    bus.wb_alu_valid = 1'b0;
    checkOutput("collide_wb_addr", 32'(bus.rf_write_addr), 32'd4);
    step();
    consume();
    applyStimulus(4'd4, 4'd0, 4'd0, 1'b0);
    step();
    step();
    step();
    checkOutput("collide_pending", 32'(bus.op_valid), 32'd0);
    alu_write(4'd4, 16'h0044);
    step();
    checkOutput("collide_release", 32'(bus.op_valid), 32'd1);
    checkOutput("collide_op_a", 32'(bus.op_a), 32'h0044);
    consume();

    // Reset while a fetch is holding and a write-back is being staged.
    applyStimulus(4'd3, 4'd5, 4'd9, 1'b1);
    step();
    checkOutput("pre_reset_hold", 32'(bus.op_valid), 32'd1);
    reset            = 1'b1;
    bus.wb_alu_valid = 1'b1;
    bus.wb_alu_addr  = 4'd6;
    bus.wb_alu_data  = 16'h6666;
    #1;
    checkOutput("midrst_op_valid", 32'(bus.op_valid), 32'd0);
    checkOutput("midrst_ready", 32'(bus.rd_req_ready), 32'd0);
    checkOutput("midrst_op_a", 32'(bus.op_a), 32'h0000);
    checkOutput("midrst_err", 32'(bus.err_addr), 32'd0);
    step();
    bus.wb_alu_valid = 1'b0;
    step();
    reset = 1'b0;
    #1;
    checkOutput("release_ready", 32'(bus.rd_req_ready), 32'd1);
    checkOutput("staged_wr_dropped", 32'(bus.rf_write_enable), 32'd0);
    checkOutput("err_cleared", 32'(bus.err_addr), 32'd0);
    applyStimulus(4'd9, 4'd6, 4'd0, 1'b0);
    wait_op(8, lat);
    checkOutput("sb_empty_after_reset", 32'(lat), 32'd1);
    checkOutput("r6_unwritten", 32'(bus.op_b), 32'h0000);
    consume();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
